// File: rtl/traffic_phase_sequencer.sv
// Two-road intersection phase sequencer: walks MG/MY/AR1/SG/SY/AR2 on a one-second
// strobe, holds main green until a side request is latched, and supports night flashing.
module traffic_phase_sequencer #(
    parameter int T_MAIN_GREEN = 19,
    parameter int T_SIDE_GREEN = 14,
    parameter int T_YELLOW     = 4,
    parameter int T_ALL_RED    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       secTick,
    input  logic       sideReq,
    input  logic       nightMode,
    output logic [2:0] mainLight,
    output logic [2:0] sideLight,
    output logic [4:0] lightTime,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        MG  = 3'd0,
        MY  = 3'd1,
        AR1 = 3'd2,
        SG  = 3'd3,
        SY  = 3'd4,
        AR2 = 3'd5,
        FL  = 3'd6
    } phase_t;

    localparam logic [4:0] LT_MAIN_GREEN = 5'(T_MAIN_GREEN);
    localparam logic [4:0] LT_SIDE_GREEN = 5'(T_SIDE_GREEN);
    localparam logic [4:0] LT_YELLOW     = 5'(T_YELLOW);
    localparam logic [4:0] LT_ALL_RED    = 5'(T_ALL_RED);

    // Lamp vectors are {red, yellow, green}.
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;
    localparam logic [2:0] LAMP_OFF = 3'b000;

    phase_t     state_q, state_nxt;
    logic [4:0] cnt_q, cnt_nxt;
    logic       req_latch, req_nxt;
    logic       flash_on, flash_nxt;
    logic [2:0] main_q, main_nxt;
    logic [2:0] side_q, side_nxt;

    // State register; lamps are registered from the next-state decode so every
    // output comes straight off a flop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update
        // together from values sampled before the edge.
        if (rst) begin
            state_q   <= MG;
            cnt_q     <= LT_MAIN_GREEN;
            req_latch <= 1'b0;
            flash_on  <= 1'b0;
            main_q    <= LAMP_GRN;
            side_q    <= LAMP_RED;
        end else begin
            state_q   <= state_nxt;
            cnt_q     <= cnt_nxt;
            req_latch <= req_nxt;
            flash_on  <= flash_nxt;
            main_q    <= main_nxt;
            side_q    <= side_nxt;
        end
    end

    // Next-state logic: only secTick cycles move the phase or the countdown.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_nxt = state_q;
        cnt_nxt   = cnt_q;
        flash_nxt = flash_on;
        req_nxt   = req_latch | sideReq;

        if (secTick) begin
            if (nightMode) begin
                state_nxt = FL;
                cnt_nxt   = 5'd0;
                flash_nxt = (state_q == FL) ? ~flash_on : 1'b1;
            end else if (state_q == FL) begin
                state_nxt = AR2;
                cnt_nxt   = LT_ALL_RED;
                flash_nxt = 1'b0;
            end else if (cnt_q != 5'd0) begin
                cnt_nxt = cnt_q - 5'd1;
            end else begin
                unique case (state_q)
                    MG: begin
                        if (req_latch) begin
                            state_nxt = MY;
                            cnt_nxt   = LT_YELLOW;
                        end else begin
                            cnt_nxt = LT_MAIN_GREEN;
                        end
                    end
                    MY: begin
                        state_nxt = AR1;
                        cnt_nxt   = LT_ALL_RED;
                    end
                    AR1: begin
                        state_nxt = SG;
                        cnt_nxt   = LT_SIDE_GREEN;
                    end
                    SG: begin
                        state_nxt = SY;
                        cnt_nxt   = LT_YELLOW;
                    end
                    SY: begin
                        state_nxt = AR2;
                        cnt_nxt   = LT_ALL_RED;
                    end
                    default: begin
                        state_nxt = MG;
                        cnt_nxt   = LT_MAIN_GREEN;
                    end
                endcase
            end
        end

        // Serving the side road consumes the request; a fresh sideReq on that same edge is dropped.
        if (state_nxt == SG && state_q != SG) begin
            req_nxt = 1'b0;
        end
    end

    // Lamp decode of the upcoming phase, so the lamp flops change with the phase flops.
    always_comb begin
        main_nxt = LAMP_RED;
        side_nxt = LAMP_RED;
        unique case (state_nxt)
            MG: begin
                main_nxt = LAMP_GRN;
                side_nxt = LAMP_RED;
            end
            MY: begin
                main_nxt = LAMP_YEL;
                side_nxt = LAMP_RED;
            end
            SG: begin
                main_nxt = LAMP_RED;
                side_nxt = LAMP_GRN;
            end
            SY: begin
                main_nxt = LAMP_RED;
                side_nxt = LAMP_YEL;
            end
            FL: begin
                main_nxt = flash_nxt ? LAMP_YEL : LAMP_OFF;
                side_nxt = flash_nxt ? LAMP_YEL : LAMP_OFF;
            end
            default: begin
                main_nxt = LAMP_RED;
                side_nxt = LAMP_RED;
            end
        endcase
    end

    assign phase     = state_q;
    assign lightTime = cnt_q;
    assign mainLight = main_q;
    assign sideLight = side_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Directed bench for traffic_phase_sequencer: reset, idle main green, side-road cycle,
// strobe hold, night flashing, reset mid-phase, and continuous requests.
module tb_traffic_phase_sequencer;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    logic       clk = 1'b0;
    logic       rst;
    logic       secTick;
    logic       sideReq;
    logic       nightMode;
    logic [2:0] mainLight;
    logic [2:0] sideLight;
    logic [4:0] lightTime;
    logic [2:0] phase;

    int vectors    = 0;
    int miscompares = 0;

    traffic_phase_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .secTick   (secTick),
        .sideReq   (sideReq),
        .nightMode (nightMode),
        .mainLight (mainLight),
        .sideLight (sideLight),
        .lightTime (lightTime),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_state(input string tag, input logic [2:0] ph, input logic [4:0] lt,
                               input logic [2:0] ml, input logic [2:0] sl);
        logic conflict;
        conflict = (phase != 3'd6) && (|mainLight[1:0]) && (|sideLight[1:0]);
        check({tag, " phase"}, 32'(phase), 32'(ph));
        check({tag, " lightTime"}, 32'(lightTime), 32'(lt));
        check({tag, " mainLight"}, 32'(mainLight), 32'(ml));
        check({tag, " sideLight"}, 32'(sideLight), 32'(sl));
        check({tag, " conflict"}, 32'(conflict), 32'd0);
    endtask

    // One clock, with or without the seconds strobe; outputs sampled 1 ns after the edge.
    task automatic step(input logic t);
        @(negedge clk);
        secTick = t;
        @(posedge clk);
        #1;
        secTick = 1'b0;
    endtask

    task automatic tick();
        step(1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0);
    endtask

    task automatic pulse_req();
        @(negedge clk);
        sideReq = 1'b1;
        @(posedge clk);
        #1;
        sideReq = 1'b0;
    endtask

    // Checks the current count, then ticks down to 0 checking every value.
    task automatic run_phase(input string tag, input logic [2:0] ph, input logic [4:0] t,
                             input logic [2:0] ml, input logic [2:0] sl);
        check_state(tag, ph, t, ml, sl);
        for (int v = int'(t) - 1; v >= 0; v--) begin
            tick();
            check_state(tag, ph, 5'(v), ml, sl);
        end
    endtask

    // From MG at count 0 with a request latched: the whole side-road cycle back to MG.
    task automatic side_cycle(input string tag);
        tick(); run_phase({tag, " MY"},  3'd1, 5'd4,  YEL, RED);
        tick(); run_phase({tag, " AR1"}, 3'd2, 5'd2,  RED, RED);
        tick(); run_phase({tag, " SG"},  3'd3, 5'd14, RED, GRN);
        tick(); run_phase({tag, " SY"},  3'd4, 5'd4,  RED, YEL);
        tick(); run_phase({tag, " AR2"}, 3'd5, 5'd2,  RED, RED);
        tick(); check_state({tag, " back MG"}, 3'd0, 5'd19, GRN, RED);
    endtask

    initial begin
        rst       = 1'b1;
        secTick   = 1'b0;
        sideReq   = 1'b0;
        nightMode = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_state("reset", 3'd0, 5'd19, GRN, RED);
        @(negedge clk);
        rst = 1'b0;

        // Main green with no request: 19..0, then reload to 19 and keep counting.
        for (int k = 1; k <= 30; k++) begin
            tick();
            check_state("idle MG", 3'd0, (k <= 19) ? 5'(19 - k) : 5'(39 - k), GRN, RED);
        end

        // No strobe for 100 clocks mid-phase: nothing moves.
        idle(100);
        check_state("hold", 3'd0, 5'd9, GRN, RED);

        // Side request at count 10, then the full side-road cycle.
        repeat (19) tick();
        check_state("pre req", 3'd0, 5'd10, GRN, RED);
        pulse_req();
        run_phase("req MG", 3'd0, 5'd10, GRN, RED);
        side_cycle("req");
        // Request was consumed on SG entry: main green simply reloads.
        run_phase("req MG2", 3'd0, 5'd19, GRN, RED);
        tick();
        check_state("req consumed", 3'd0, 5'd19, GRN, RED);

        // Night mode raised during SG at count 7.
        pulse_req();
        run_phase("night MG", 3'd0, 5'd19, GRN, RED);
        tick(); run_phase("night MY",  3'd1, 5'd4, YEL, RED);
        tick(); run_phase("night AR1", 3'd2, 5'd2, RED, RED);
        tick(); check_state("night SG", 3'd3, 5'd14, RED, GRN);
        repeat (7) tick();
        check_state("night SG7", 3'd3, 5'd7, RED, GRN);
        @(negedge clk);
        nightMode = 1'b1;
        idle(3);
        check_state("night no strobe", 3'd3, 5'd7, RED, GRN);
        tick(); check_state("flash on",   3'd6, 5'd0, YEL, YEL);
        tick(); check_state("flash off",  3'd6, 5'd0, OFF, OFF);
        tick(); check_state("flash on2",  3'd6, 5'd0, YEL, YEL);
        tick(); check_state("flash off2", 3'd6, 5'd0, OFF, OFF);
        @(negedge clk);
        nightMode = 1'b0;
        idle(3);
        check_state("day no strobe", 3'd6, 5'd0, OFF, OFF);
        tick();
        run_phase("day AR2", 3'd5, 5'd2, RED, RED);
        tick();
        check_state("day MG", 3'd0, 5'd19, GRN, RED);

        // Reset in SY at count 3, with a request pending and a strobe on the same edge.
        pulse_req();
        run_phase("rst MG", 3'd0, 5'd19, GRN, RED);
        tick(); run_phase("rst MY",  3'd1, 5'd4,  YEL, RED);
        tick(); run_phase("rst AR1", 3'd2, 5'd2,  RED, RED);
        tick(); run_phase("rst SG",  3'd3, 5'd14, RED, GRN);
        tick(); check_state("rst SY4", 3'd4, 5'd4, RED, YEL);
        tick(); check_state("rst SY3", 3'd4, 5'd3, RED, YEL);
        pulse_req();
        @(negedge clk);
        rst     = 1'b1;
        secTick = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        secTick = 1'b0;
        check_state("mid reset", 3'd0, 5'd19, GRN, RED);
        run_phase("post rst MG", 3'd0, 5'd19, GRN, RED);
        tick();
        check_state("rst cleared req", 3'd0, 5'd19, GRN, RED);

        // Continuous request: cycle repeats straight back into MY.
        @(negedge clk);
        sideReq = 1'b1;
        run_phase("cont MG", 3'd0, 5'd19, GRN, RED);
        side_cycle("cont");
        run_phase("cont MG2", 3'd0, 5'd19, GRN, RED);
        tick();
        check_state("cont MY again", 3'd1, 5'd4, YEL, RED);
        @(negedge clk);
        sideReq = 1'b0;
        run_phase("clr MY",  3'd1, 5'd4, YEL, RED);
        tick(); run_phase("clr AR1", 3'd2, 5'd2, RED, RED);
        // sideReq on the SG-entry edge itself must not survive the clear.
        @(negedge clk);
        secTick = 1'b1;
        sideReq = 1'b1;
        @(posedge clk);
        #1;
        secTick = 1'b0;
        sideReq = 1'b0;
        run_phase("clr SG", 3'd3, 5'd14, RED, GRN);
        tick(); run_phase("clr SY",  3'd4, 5'd4, RED, YEL);
        tick(); run_phase("clr AR2", 3'd5, 5'd2, RED, RED);
        tick(); run_phase("clr MG",  3'd0, 5'd19, GRN, RED);
        tick();
        check_state("clear wins", 3'd0, 5'd19, GRN, RED);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
